// File: rtl/galaga_clk_pkg.sv
// Shared definitions for the Galaga clock/reset sequencer: FSM state
// encoding, default parameter values and a counter-width helper.
package galaga_clk_pkg;

  // Two-bit state encoding kept as plain constants so the values stay
  // visible in netlists and in older tools.
  typedef logic [1:0] state_t;

  localparam state_t WAIT_LOCK = 2'd0;
  localparam state_t STABILIZE = 2'd1;
  localparam state_t RUN       = 2'd2;

  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_STABLE_CYCLES = 1024;
  localparam int DEF_PIX_DIV       = 3;
  localparam int DEF_CPU_RATIO     = 2;

  // Bits needed to count 0..limit-1, never less than one bit.
  function automatic int cnt_width(input int limit);
    return (limit < 2) ? 1 : $clog2(limit);
  endfunction

endpackage

// File: rtl/galaga_bit_sync.sv
// N-stage single-bit synchroniser with asynchronous active-high reset to 0.
// Used to bring the PLL lock flag into the 18 MHz domain.
module galaga_bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= '0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the value from
      // before the edge; blocking here would collapse the chain into one flop.
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/galaga_clkrst_seq.sv
// Galaga clock/reset sequencer. Qualifies the PLL lock flag, releases a
// clean core reset after a stable-lock interval and generates the pixel and
// CPU clock-enables from the 18 MHz clock.
// Optional build macro: GALAGA_LOCK_LOSS_CNT_EN adds an 8-bit saturating
// count of RUN -> WAIT_LOCK transitions on port lock_loss_cnt.
module galaga_clkrst_seq
  import galaga_clk_pkg::*;
#(
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int PIX_DIV       = DEF_PIX_DIV,
  parameter int CPU_RATIO     = DEF_CPU_RATIO
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pll_locked,
  output logic       sys_reset,
  output logic       ce_pix,
  output logic       ce_cpu,
`ifdef GALAGA_LOCK_LOSS_CNT_EN
  output logic       ready,
  output logic [7:0] lock_loss_cnt
`else
  output logic       ready
`endif
);

  localparam int STAB_W = cnt_width(STABLE_CYCLES);
  localparam int PIX_W  = cnt_width(PIX_DIV);
  localparam int CPU_W  = cnt_width(CPU_RATIO);

  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);
  localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(PIX_DIV - 1);
  localparam logic [CPU_W-1:0]  CPU_LAST  = CPU_W'(CPU_RATIO - 1);

  logic              w_locked_s;
  state_t            r_state;
  state_t            w_state_next;
  logic [STAB_W-1:0] r_stable_cnt;
  logic [STAB_W-1:0] w_stable_next;
  logic              w_run_next;
  logic              r_sys_reset;
  logic              r_ready;
  logic [PIX_W-1:0]  r_pix_cnt;
  logic [CPU_W-1:0]  r_cpu_cnt;
  logic              w_pix_wrap;
  logic              w_cpu_wrap;
  logic              r_ce_pix;
  logic              r_ce_cpu;

  // The only path by which pll_locked enters this clock domain.
  galaga_bit_sync #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk   (clk),
    .reset (reset),
    .i_d   (pll_locked),
    .o_q   (w_locked_s)
  );

  // Next-state and stable-counter logic; a lock drop always wins over completion.
  always_comb begin
    // NOTE: every output of this block gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    w_state_next  = r_state;
    w_stable_next = '0;
    case (r_state)
      WAIT_LOCK: begin
        if (w_locked_s) w_state_next = STABILIZE;
      end
      STABILIZE: begin
        if (!w_locked_s) begin
          w_state_next = WAIT_LOCK;
        end else if (r_stable_cnt == STAB_LAST) begin
          w_state_next = RUN;
        end else begin
          w_stable_next = r_stable_cnt + STAB_W'(1);
        end
      end
      RUN: begin
        if (!w_locked_s) w_state_next = WAIT_LOCK;
      end
      default: w_state_next = WAIT_LOCK;
    endcase
  end

  // Outputs are decided from the next state so they change on the same edge
  // as the state itself.
  assign w_run_next = (w_state_next == RUN);
  assign w_pix_wrap = (r_pix_cnt == PIX_LAST);
  assign w_cpu_wrap = (r_cpu_cnt == CPU_LAST);

  // State register with registered reset/ready outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: every flop here has a defined reset value; the outputs must be
      // correct immediately on reset, before any clock edge arrives.
      r_state      <= WAIT_LOCK;
      r_stable_cnt <= '0;
      r_sys_reset  <= 1'b1;
      r_ready      <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_stable_cnt <= w_stable_next;
      r_sys_reset  <= !w_run_next;
      r_ready      <= w_run_next;
    end
  end

  // Pixel and CPU dividers; held at zero whenever the sequencer is not running.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pix_cnt <= '0;
      r_cpu_cnt <= '0;
      r_ce_pix  <= 1'b0;
      r_ce_cpu  <= 1'b0;
    end else if (!w_run_next) begin
      r_pix_cnt <= '0;
      r_cpu_cnt <= '0;
      r_ce_pix  <= 1'b0;
      r_ce_cpu  <= 1'b0;
    end else begin
      r_pix_cnt <= w_pix_wrap ? '0 : r_pix_cnt + PIX_W'(1);
      r_ce_pix  <= w_pix_wrap;
      r_ce_cpu  <= w_pix_wrap && w_cpu_wrap;
      if (w_pix_wrap) begin
        r_cpu_cnt <= w_cpu_wrap ? '0 : r_cpu_cnt + CPU_W'(1);
      end
    end
  end

  assign sys_reset = r_sys_reset;
  assign ready     = r_ready;
  assign ce_pix    = r_ce_pix;
  assign ce_cpu    = r_ce_cpu;

`ifdef GALAGA_LOCK_LOSS_CNT_EN
  logic       w_lock_lost;
  logic [7:0] r_lock_loss_cnt;

  // Only a drop out of RUN counts; aborted stabilisation attempts do not.
  assign w_lock_lost = (r_state == RUN) && (w_state_next == WAIT_LOCK);

  // Saturating lock-loss counter, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lock_loss_cnt <= 8'd0;
    end else if (w_lock_lost && (r_lock_loss_cnt != 8'hFF)) begin
      r_lock_loss_cnt <= r_lock_loss_cnt + 8'd1;
    end
  end

  assign lock_loss_cnt = r_lock_loss_cnt;
`else
`endif

endmodule

// File: tb/tb_galaga_clkrst_seq.sv
// Self-checking bench for galaga_clkrst_seq (STABLE_CYCLES = 16, others
// default). A lock-streak reference model predicts every output each cycle;
// directed phases measure release/drop latencies and divider phase.
module tb_galaga_clkrst_seq;

  localparam int SYNC     = 2;
  localparam int STABLE   = 16;
  localparam int PIX      = 3;
  localparam int CPU      = 2;
  localparam int REL_LAT  = SYNC + STABLE + 1;
  localparam int DROP_LAT = SYNC + 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic pll_locked = 1'b0;
  logic sys_reset;
  logic ce_pix;
  logic ce_cpu;
  logic ready;
`ifdef GALAGA_LOCK_LOSS_CNT_EN
  logic [7:0] lock_loss_cnt;
`endif

  always #5 clk = ~clk;

  galaga_clkrst_seq #(
    .SYNC_STAGES   (SYNC),
    .STABLE_CYCLES (STABLE),
    .PIX_DIV       (PIX),
    .CPU_RATIO     (CPU)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .pll_locked    (pll_locked),
    .sys_reset     (sys_reset),
    .ce_pix        (ce_pix),
    .ce_cpu        (ce_cpu),
`ifdef GALAGA_LOCK_LOSS_CNT_EN
    .ready         (ready),
    .lock_loss_cnt (lock_loss_cnt)
`else
    .ready         (ready)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: the core runs once the lock flag, as seen through the
  // synchroniser delay, has been high for STABLE+1 consecutive decisions.
  bit m_hist[$];
  int m_streak;
  int m_run_len;
  int m_loss;
  bit m_run;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_hist.delete();
    for (int i = 0; i < SYNC; i++) m_hist.push_back(1'b0);
    m_streak  = 0;
    m_run_len = 0;
    m_loss    = 0;
    m_run     = 1'b0;
  endtask

  task automatic model_edge(input bit lk);
    bit seen;
    bit prev;
    if (reset) begin
      model_reset();
      return;
    end
    seen = m_hist.pop_front();
    m_hist.push_back(lk);
    prev      = m_run;
    m_streak  = seen ? m_streak + 1 : 0;
    m_run     = (m_streak >= STABLE + 1);
    m_run_len = m_run ? m_run_len + 1 : 0;
    if (prev && !m_run && m_loss < 255) m_loss++;
  endtask

  task automatic compare_all(input string tag);
    bit exp_pix;
    bit exp_cpu;
    exp_pix = m_run && (m_run_len % PIX == 0);
    exp_cpu = m_run && (m_run_len % (PIX * CPU) == 0);
    check({tag, ".sys_reset"}, {31'b0, sys_reset}, {31'b0, ~m_run});
    check({tag, ".ready"},     {31'b0, ready},     {31'b0, m_run});
    check({tag, ".ce_pix"},    {31'b0, ce_pix},    {31'b0, exp_pix});
    check({tag, ".ce_cpu"},    {31'b0, ce_cpu},    {31'b0, exp_cpu});
    check({tag, ".cpu_wo_pix"}, {31'b0, ce_cpu & ~ce_pix}, 32'd0);
`ifdef GALAGA_LOCK_LOSS_CNT_EN
    check({tag, ".loss_cnt"}, {24'b0, lock_loss_cnt}, 32'(m_loss));
`endif
  endtask

  // One clock: inputs change on the falling edge, outputs checked 1 after rise.
  task automatic step(input string tag, input logic lk, input logic rst = 1'b0);
    @(negedge clk);
    pll_locked = lk;
    reset      = rst;
    #1;
    if (rst) begin
      model_reset();
      compare_all({tag, ".async"});
    end
    @(posedge clk);
    model_edge(lk);
    #1;
    compare_all(tag);
  endtask

  // Reset pulse that starts and ends inside one clock low phase; the
  // following rising edge is the first to sample pll_locked again.
  task automatic reset_pulse(input string tag, input logic lk);
    @(negedge clk);
    pll_locked = lk;
    reset      = 1'b1;
    #1;
    model_reset();
    compare_all({tag, ".async"});
    #1;
    reset = 1'b0;
    @(posedge clk);
    model_edge(lk);
    #1;
    compare_all(tag);
  endtask

  // Edges (counting the first lock-sampling edge as 1) until sys_reset falls.
  task automatic measure_release(input string tag, input int n0, output int n);
    n = n0;
    do begin
      step(tag, 1'b1);
      n++;
    end while (sys_reset !== 1'b0 && n < 200);
  endtask

  // Edges after pll_locked falls until sys_reset rises.
  task automatic measure_drop(input string tag, output int n);
    n = 0;
    do begin
      step(tag, 1'b0);
      n++;
    end while (sys_reset !== 1'b1 && n < 50);
  endtask

  initial begin
    int n;
    model_reset();

    // Held reset, then a long unlocked period.
    repeat (5) step("in_reset", 1'b0, 1'b1);
    repeat (100) step("unlocked", 1'b0);

    // First lock: release latency and divider phase.
    measure_release("first_lock", 0, n);
    check("first_release_edges", n, REL_LAT);
    for (int k = 1; k <= 12; k++) begin
      step("divider_phase", 1'b1);
      check("ce_pix_phase", {31'b0, ce_pix}, {31'b0, ((k + 1) % PIX == 0)});
      check("ce_cpu_phase", {31'b0, ce_cpu}, {31'b0, ((k + 1) % (PIX * CPU) == 0)});
    end
    repeat (37) step("run", 1'b1);

    // Lock loss after 50 RUN cycles.
    measure_drop("lock_drop", n);
    check("drop_edges", n, DROP_LAT);
    check("drop_ce_pix", {31'b0, ce_pix}, 32'd0);
    check("drop_ce_cpu", {31'b0, ce_cpu}, 32'd0);
`ifdef GALAGA_LOCK_LOSS_CNT_EN
    check("loss_after_drop", {24'b0, lock_loss_cnt}, 32'd1);
`endif

    // Single-cycle lock glitch during STABILIZE at count 10, then relock.
    repeat (11) step("stabilize", 1'b1);
    step("glitch", 1'b0);
    measure_release("relock", 0, n);
    check("relock_release_edges", n, REL_LAT);

    // Asynchronous reset pulse in RUN, lock kept high throughout.
    repeat (10) step("run2", 1'b1);
    reset_pulse("mid_run_reset", 1'b1);
    measure_release("post_reset", 1, n);
    check("post_reset_release_edges", n, REL_LAT);

    // Randomised lock activity with occasional reset pulses.
    for (int s = 0; s < 40; s++) begin
      int hi;
      int lo;
      hi = $urandom_range(1, 45);
      lo = $urandom_range(1, 4);
      if ($urandom_range(0, 7) == 0) reset_pulse("rand_reset", 1'(($urandom_range(0, 1))));
      repeat (hi) step("rand_hi", 1'b1);
      repeat (lo) step("rand_lo", 1'b0);
    end

    // Many complete lock/run/drop cycles to reach counter saturation.
    reset_pulse("sat_reset", 1'b0);
    for (int e = 0; e < 300; e++) begin
      repeat (REL_LAT + $urandom_range(1, 4)) step("sat_hi", 1'b1);
      repeat (DROP_LAT) step("sat_lo", 1'b0);
    end
`ifdef GALAGA_LOCK_LOSS_CNT_EN
    check("loss_saturated", {24'b0, lock_loss_cnt}, 32'd255);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
